// File: rtl/ctrl_pipe_pkg.sv
// Shared widths, stage-register payloads, bubble constants and forwarding encodings.
package ctrl_pipe_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned MTR_W   = 2;
    localparam int unsigned FWD_W   = 2;

    localparam logic [MTR_W-1:0] BUBBLE_MEMTOREG = 2'b11;

    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src1;
        logic               alu_src2;
        logic               reg_write;
        logic               pc_enable;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
        logic [MTR_W-1:0]   mem_to_reg;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
    } idex_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [MTR_W-1:0]  mem_to_reg;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              reg_write;
        logic [MTR_W-1:0]  mem_to_reg;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    localparam idex_t IDEX_BUBBLE = '{
        branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0, alu_src1: 1'b0,
        alu_src2: 1'b0, reg_write: 1'b0, pc_enable: 1'b1, jump: 1'b0,
        alu_op: '0, mem_to_reg: BUBBLE_MEMTOREG, rs1: '0, rs2: '0, rd: '0
    };

    localparam exmem_t EXMEM_BUBBLE = '{
        mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
        mem_to_reg: BUBBLE_MEMTOREG, rd: '0
    };

    localparam memwb_t MEMWB_BUBBLE = '{
        reg_write: 1'b0, mem_to_reg: BUBBLE_MEMTOREG, rd: '0
    };

    // x0 is never a producer, so rd 0 never matches a source register.
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// Combinational load-use detection and operand forwarding selects.
module ctrl_pipe_hazard_fwd_unit
    import ctrl_pipe_pkg::*;
(
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              load_use,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b
);

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = ex_mem_read && (reg_hit(ex_rd, id_rs1) || reg_hit(ex_rd, id_rs2));
    end

    // Youngest producer wins: EX/MEM before MEM/WB before the register file.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_reg_write && reg_hit(mem_rd, ex_rs1))     fwd_a = FWD_EXMEM;
        else if (wb_reg_write && reg_hit(wb_rd, ex_rs1))  fwd_a = FWD_MEMWB;
        if (mem_reg_write && reg_hit(mem_rd, ex_rs2))     fwd_b = FWD_EXMEM;
        else if (wb_reg_write && reg_hit(wb_rd, ex_rs2))  fwd_b = FWD_MEMWB;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-side pipeline: ID/EX, EX/MEM, MEM/WB stage registers, stalls, flushes and halt.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_branch,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_ALUsrc1,
    input  logic              id_ALUsrc2,
    input  logic              id_regWrite,
    input  logic              id_PC_enable,
    input  logic              id_jump,
    input  logic [1:0]        id_ALUop,
    input  logic [1:0]        id_memToReg,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    output logic              ex_branch,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic              ex_ALUsrc1,
    output logic              ex_ALUsrc2,
    output logic              ex_regWrite,
    output logic              ex_jump,
    output logic [1:0]        ex_ALUop,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic              mem_regWrite,
    output logic [1:0]        mem_memToReg,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_regWrite,
    output logic [1:0]        wb_memToReg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              halted
);

    idex_t  idex_q,   idex_d;
    exmem_t exmem_q,  exmem_d;
    memwb_t memwb_q,  memwb_d;
    logic   halted_q, halted_d;
    logic   load_use;
    logic   stall_eff;

    ctrl_pipe_hazard_fwd_unit u_hazard_fwd_unit (
        .ex_mem_read   (idex_q.mem_read),
        .ex_rd         (idex_q.rd),
        .ex_rs1        (idex_q.rs1),
        .ex_rs2        (idex_q.rs2),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .mem_reg_write (exmem_q.reg_write),
        .mem_rd        (exmem_q.rd),
        .wb_reg_write  (memwb_q.reg_write),
        .wb_rd         (memwb_q.rd),
        .load_use      (load_use),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Next stage contents and front-end enables; a redirect squashes any stall.
    always_comb begin
        idex_d     = IDEX_BUBBLE;
        exmem_d    = EXMEM_BUBBLE;
        memwb_d    = MEMWB_BUBBLE;
        halted_d   = halted_q | ~idex_q.pc_enable;
        stall_eff  = load_use & ~ex_redirect;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;

        if (!(halted_q || ex_redirect || load_use)) begin
            idex_d = '{
                branch: id_branch, mem_read: id_memRead, mem_write: id_memWrite,
                alu_src1: id_ALUsrc1, alu_src2: id_ALUsrc2, reg_write: id_regWrite,
                pc_enable: id_PC_enable, jump: id_jump, alu_op: id_ALUop,
                mem_to_reg: id_memToReg, rs1: id_rs1, rs2: id_rs2, rd: id_rd
            };
        end

        exmem_d = '{
            mem_read: idex_q.mem_read, mem_write: idex_q.mem_write,
            reg_write: idex_q.reg_write, mem_to_reg: idex_q.mem_to_reg, rd: idex_q.rd
        };
        memwb_d = '{
            reg_write: exmem_q.reg_write, mem_to_reg: exmem_q.mem_to_reg, rd: exmem_q.rd
        };

        if (stall_eff) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
        if (ex_redirect) ifid_flush = 1'b1;
        if (!idex_q.pc_enable) pc_write = 1'b0;
        if (halted_q) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // Stage registers and sticky halt; reset forces bubbles everywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q   <= IDEX_BUBBLE;
            exmem_q  <= EXMEM_BUBBLE;
            memwb_q  <= MEMWB_BUBBLE;
            halted_q <= 1'b0;
        end else begin
            idex_q   <= idex_d;
            exmem_q  <= exmem_d;
            memwb_q  <= memwb_d;
            halted_q <= halted_d;
        end
    end

    assign ex_branch    = idex_q.branch;
    assign ex_memRead   = idex_q.mem_read;
    assign ex_memWrite  = idex_q.mem_write;
    assign ex_ALUsrc1   = idex_q.alu_src1;
    assign ex_ALUsrc2   = idex_q.alu_src2;
    assign ex_regWrite  = idex_q.reg_write;
    assign ex_jump      = idex_q.jump;
    assign ex_ALUop     = idex_q.alu_op;
    assign ex_rd        = idex_q.rd;
    assign mem_memRead  = exmem_q.mem_read;
    assign mem_memWrite = exmem_q.mem_write;
    assign mem_regWrite = exmem_q.reg_write;
    assign mem_memToReg = exmem_q.mem_to_reg;
    assign mem_rd       = exmem_q.rd;
    assign wb_regWrite  = memwb_q.reg_write;
    assign wb_memToReg  = memwb_q.mem_to_reg;
    assign wb_rd        = memwb_q.rd;
    assign halted       = halted_q;

endmodule
